// File: rtl/alu_issue_sequencer_pkg.sv
// Shared constants and FSM state type for the ALU issue sequencer.
package alu_issue_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;

  localparam logic [3:0] REQ_REGNUM = 4'b0011;
  localparam logic [3:0] REQ_VALUE  = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_sequencer_regfile16x4.sv
// 16x4 register file: one synchronous write port, two combinational read
// ports (operand and debug). r0 is hardwired to zero.
module regfile16x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [3:0] wdata,
  input  logic [3:0] raddr,
  output logic [3:0] rdata,
  input  logic [3:0] daddr,
  output logic [3:0] ddata
);

  logic [3:0] mem [16];

  // Write port; writes to r0 are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read ports with r0 forced to zero.
  always_comb begin
    rdata = (raddr == 4'd0) ? 4'd0 : mem[raddr];
    ddata = (daddr == 4'd0) ? 4'd0 : mem[daddr];
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue stage for the 4-bit ALU execution unit: accepts host instructions,
// drives the unit, answers its operand bus requests and writes back results.
module alu_issue_sequencer
  import alu_issue_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [3:0] instr_imm,
  input  logic [3:0] instr_rs,
  input  logic [3:0] instr_rd,
  output logic [3:0] ex_opcode,
  output logic [3:0] ex_imm,
  input  logic [3:0] ex_bus_req,
  output logic [3:0] ex_operand,
  output logic       ex_operand_oe,
  input  logic [3:0] ex_result,
  input  logic       ex_done,
  input  logic       ex_carry,
  input  logic [3:0] dbg_addr,
  output logic [3:0] dbg_data,
  output logic       carry_flag,
  output logic       busy,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] imm_q, rs_q, rd_q, opnd_q, res_q, cnt_q;
  logic       res_carry_q, carry_flag_q, done_q, illegal_q, timeout_q;
  logic       done_rise, ld, ill_set, to_set, wb_en;
  logic [3:0] rf_opnd;

  assign done_rise = ex_done && !done_q;

  regfile16x4 u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_en),
    .waddr (rd_q),
    .wdata (res_q),
    .raddr (instr_rs),
    .rdata (rf_opnd),
    .daddr (dbg_addr),
    .ddata (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and unit control; done_rise suppresses the opcode in the
  // same cycle so the unit does not restart.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ill_set   = 1'b0;
    to_set    = 1'b0;
    wb_en     = 1'b0;
    ex_opcode = OP_NOP;
    unique case (state)
      S_IDLE: begin
        if (instr_valid) begin
          if (instr_op == OP_ADDI) begin
            ld        = 1'b1;
            state_nxt = S_EXEC;
          end else if (instr_op != OP_NOP) begin
            ill_set = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (done_rise) begin
          state_nxt = S_WB;
        end else begin
          ex_opcode = OP_ADDI;
          if (cnt_q == TO_LAST) begin
            to_set    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WB: begin
        wb_en     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand bus answer, only while executing.
  always_comb begin
    ex_operand    = '0;
    ex_operand_oe = 1'b0;
    if (state == S_EXEC) begin
      if (ex_bus_req == REQ_REGNUM) begin
        ex_operand    = rs_q;
        ex_operand_oe = 1'b1;
      end else if (ex_bus_req == REQ_VALUE) begin
        ex_operand    = opnd_q;
        ex_operand_oe = 1'b1;
      end
    end
  end

  // Instruction latches, timeout counter, result capture and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q        <= '0;
      rs_q         <= '0;
      rd_q         <= '0;
      opnd_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      res_carry_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q    <= ex_done;
      illegal_q <= ill_set;
      timeout_q <= to_set;
      if (ld) begin
        imm_q  <= instr_imm;
        rs_q   <= instr_rs;
        rd_q   <= instr_rd;
        opnd_q <= rf_opnd;
        cnt_q  <= '0;
      end else if (state == S_EXEC) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if ((state == S_EXEC) && done_rise) begin
        res_q       <= ex_result;
        res_carry_q <= ex_carry;
      end
      if (wb_en) carry_flag_q <= res_carry_q;
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign ex_imm      = imm_q;
  assign carry_flag  = carry_flag_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer with an in-bench ALU unit model
// and an architectural register-file model.
module tb_alu_issue_sequencer;
  import alu_issue_sequencer_pkg::*;

  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op, instr_imm, instr_rs, instr_rd;
  logic [3:0] ex_opcode, ex_imm, ex_bus_req, ex_operand, ex_result;
  logic       ex_operand_oe, ex_done, ex_carry;
  logic [3:0] dbg_addr, dbg_data;
  logic       carry_flag, busy, illegal, timeout;

  int tests = 0;
  int fails = 0;

  logic [3:0] rf_m [16];
  logic       carry_m;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .instr_rs(instr_rs), .instr_rd(instr_rd),
    .ex_opcode(ex_opcode), .ex_imm(ex_imm), .ex_bus_req(ex_bus_req),
    .ex_operand(ex_operand), .ex_operand_oe(ex_operand_oe),
    .ex_result(ex_result), .ex_done(ex_done), .ex_carry(ex_carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .carry_flag(carry_flag), .busy(busy), .illegal(illegal), .timeout(timeout)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) rf_m[i] = 4'd0;
    carry_m = 1'b0;
  endtask

  task automatic sweep_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      tests++;
      if (dbg_data !== rf_m[i]) begin
        fails++;
        $display("FAIL %s r%0d: got %h expected %h", tag, i, dbg_data, rf_m[i]);
      end
    end
  endtask

  // Present one instruction in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] imm,
                       input logic [3:0] rs, input logic [3:0] rd);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_imm = imm; instr_rs = rs; instr_rd = rd;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = $urandom_range(15, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_imm = '0;
    instr_rs = '0; instr_rd = '0; ex_bus_req = '0; ex_result = '0;
    ex_done = 1'b0; ex_carry = 1'b0; dbg_addr = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep_regs("reset_rf");
    tests++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_ready: ready=%b busy=%b expected 1/0", instr_ready, busy);
    end
    tests++;
    if (ex_opcode !== 4'd0 || ex_imm !== 4'd0 || ex_operand !== 4'd0 || ex_operand_oe !== 1'b0) begin
      fails++;
      $display("FAIL reset_ex: opc=%h imm=%h opnd=%h oe=%b expected 0", ex_opcode, ex_imm, ex_operand, ex_operand_oe);
    end
    tests++;
    if (carry_flag !== 1'b0 || illegal !== 1'b0 || timeout !== 1'b0) begin
      fails++; $display("FAIL reset_flags: carry=%b ill=%b to=%b expected 0", carry_flag, illegal, timeout);
    end
  endtask

  // Full ADDI with the unit model: bus requests, done edge, writeback timing.
  task automatic run_addi(input logic [3:0] imm, input logic [3:0] rs,
                          input logic [3:0] rd, input bit pre_done);
    logic [4:0] sum;
    logic [3:0] other;
    logic [3:0] old_rd;
    sum = {1'b0, imm} + {1'b0, rf_m[rs]};
    old_rd = rf_m[rd];
    if (pre_done) ex_done = 1'b1;
    issue(OP_ADDI, imm, rs, rd);
    // cycle A..A+1
    ex_bus_req = REQ_REGNUM;
    #1;
    tests++;
    if (ex_opcode !== 4'd1 || ex_imm !== imm || instr_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL exec_drive: opc=%h imm=%h rdy=%b busy=%b expected 1/%h/0/1", ex_opcode, ex_imm, instr_ready, busy, imm);
    end
    tests++;
    if (ex_operand !== rs || ex_operand_oe !== 1'b1) begin
      fails++; $display("FAIL bus_regnum: got %h oe=%b expected %h oe=1", ex_operand, ex_operand_oe, rs);
    end
    @(negedge clk);
    ex_done = 1'b0;
    ex_bus_req = REQ_VALUE;
    #1;
    tests++;
    if (ex_operand !== rf_m[rs] || ex_operand_oe !== 1'b1) begin
      fails++; $display("FAIL bus_value: got %h oe=%b expected %h oe=1", ex_operand, ex_operand_oe, rf_m[rs]);
    end
    @(negedge clk);
    do other = 4'($urandom_range(15, 0)); while (other == REQ_VALUE || other == REQ_REGNUM);
    ex_bus_req = other;
    #1;
    tests++;
    if (ex_operand !== 4'd0 || ex_operand_oe !== 1'b0) begin
      fails++; $display("FAIL bus_other req=%h: got %h oe=%b expected 0 oe=0", other, ex_operand, ex_operand_oe);
    end
    repeat (3) @(negedge clk);
    ex_bus_req = '0;
    tests++;
    if (ex_opcode !== 4'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL exec_hold: opc=%h busy=%b expected 1/1", ex_opcode, busy);
    end
    // cycle A+5..A+6: unit reports done
    ex_result = sum[3:0];
    ex_carry  = sum[4];
    ex_done   = 1'b1;
    #1;
    tests++;
    if (ex_opcode !== 4'd0) begin
      fails++; $display("FAIL done_rise_opcode: got %h expected 0", ex_opcode);
    end
    // cycle A+6..A+7: writeback, not yet visible
    @(negedge clk);
    ex_result = 4'($urandom_range(15, 0));
    ex_carry  = 1'($urandom_range(1, 0));
    dbg_addr = rd;
    #1;
    tests++;
    if (busy !== 1'b1 || instr_ready !== 1'b0 || ex_opcode !== 4'd0 || dbg_data !== ((rd == 0) ? 4'd0 : old_rd)) begin
      fails++;
      $display("FAIL wb_cycle: busy=%b rdy=%b opc=%h dbg=%h expected 1/0/0/%h", busy, instr_ready, ex_opcode, dbg_data, old_rd);
    end
    @(negedge clk);
    ex_done = 1'b0;
    if (rd != 4'd0) rf_m[rd] = sum[3:0];
    carry_m = sum[4];
    #1;
    tests++;
    if (instr_ready !== 1'b1 || dbg_data !== rf_m[rd] || carry_flag !== carry_m) begin
      fails++;
      $display("FAIL writeback rd=%0d: rdy=%b dbg=%h carry=%b expected 1/%h/%b", rd, instr_ready, dbg_data, carry_flag, rf_m[rd], carry_m);
    end
  endtask

  task automatic test_directed();
    run_addi(4'd5, 4'd0, 4'd3, 1'b0);
    run_addi(4'd9, 4'd3, 4'd4, 1'b0);
    dbg_addr = 4'd4; #1;
    tests++;
    if (dbg_data !== 4'd14 || carry_flag !== 1'b0) begin
      fails++; $display("FAIL r4_value: got %h carry=%b expected e/0", dbg_data, carry_flag);
    end
    run_addi(4'd7, 4'd4, 4'd5, 1'b0);
    dbg_addr = 4'd5; #1;
    tests++;
    if (dbg_data !== 4'd5 || carry_flag !== 1'b1) begin
      fails++; $display("FAIL r5_value: got %h carry=%b expected 5/1", dbg_data, carry_flag);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] op;
    for (int k = 0; k < 4; k++) begin
      op = (k == 0) ? 4'd6 : 4'($urandom_range(15, 2));
      issue(op, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 1)));
      tests++;
      if (illegal !== 1'b1 || instr_ready !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("FAIL illegal_pulse op=%h: ill=%b rdy=%b busy=%b expected 1/1/0", op, illegal, instr_ready, busy);
      end
      @(negedge clk);
      tests++;
      if (illegal !== 1'b0) begin
        fails++; $display("FAIL illegal_once op=%h: got %b expected 0", op, illegal);
      end
    end
    issue(OP_NOP, 4'd3, 4'd3, 4'd3);
    tests++;
    if (illegal !== 1'b0 || instr_ready !== 1'b1) begin
      fails++; $display("FAIL nop: ill=%b rdy=%b expected 0/1", illegal, instr_ready);
    end
    sweep_regs("after_illegal");
  endtask

  task automatic test_timeout();
    logic exp_to, exp_rdy;
    issue(OP_ADDI, 4'd1, 4'd5, 4'd7);
    for (int i = 0; i <= TO + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) ex_bus_req = REQ_VALUE;
      #1;
      exp_to  = (i == TO);
      exp_rdy = (i >= TO);
      tests++;
      if (timeout !== exp_to || instr_ready !== exp_rdy) begin
        fails++;
        $display("FAIL timeout cyc%0d: to=%b rdy=%b expected %b/%b", i, timeout, instr_ready, exp_to, exp_rdy);
      end
    end
    ex_bus_req = '0;
    sweep_regs("after_timeout");
    tests++;
    if (carry_flag !== carry_m) begin
      fails++; $display("FAIL timeout_carry: got %b expected %b", carry_flag, carry_m);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_addi(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
               4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    sweep_regs("after_random");
  endtask

  task automatic test_back_to_back();
    run_addi(4'd15, 4'd0, 4'd1, 1'b0);
    run_addi(4'd1, 4'd1, 4'd1, 1'b0);
    run_addi(4'd2, 4'd1, 4'd2, 1'b0);
    dbg_addr = 4'd2; #1;
    tests++;
    if (dbg_data !== 4'd2 || carry_flag !== 1'b0) begin
      fails++; $display("FAIL b2b_chain: got %h carry=%b expected 2/0", dbg_data, carry_flag);
    end
  endtask

  task automatic test_r0_and_reset();
    run_addi(4'd12, 4'd5, 4'd0, 1'b0);
    dbg_addr = 4'd0; #1;
    tests++;
    if (dbg_data !== 4'd0) begin
      fails++; $display("FAIL r0_zero: got %h expected 0", dbg_data);
    end
    issue(OP_ADDI, 4'd2, 4'd3, 4'd6);
    #1;
    tests++;
    if (ex_opcode !== 4'd1) begin
      fails++; $display("FAIL pre_rst_opcode: got %h expected 1", ex_opcode);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ex_opcode !== 4'd0 || instr_ready !== 1'b1 || carry_flag !== 1'b0) begin
      fails++; $display("FAIL async_rst: opc=%h rdy=%b carry=%b expected 0/1/0", ex_opcode, instr_ready, carry_flag);
    end
    clear_model();
    sweep_regs("mid_exec_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      fails++; $display("FAIL post_rst: busy=%b to=%b expected 0/0", busy, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    test_random();
    test_back_to_back();
    test_r0_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
